matmul_share_sched: RTL and testbench
=====================================

// Module: matmul_share_sched
// PURPOSE
//  Round-robin scheduler sharing one 3x3 signed fixed-point Mat_Mul unit among NREQ requesters
//  (e.g. the N*inv(M) and (.)*N products of the matrix-sqrt iteration, plus a checker).
//  Latches the granted requester's operands, drives the multiplier enable, waits for its
//  data-valid, and returns the 9-element result with a one-cycle done pulse to that requester.
//  A watchdog aborts a job if the multiplier never answers.
// PARAMETERS
//  W        33    element width, signed two's complement, Q.6 (1.0 = 64)
//  NREQ     3     number of requesters (2..8)
//  TIMEOUT  64    max cycles from issue to multiplier valid before abort
// PORTS
//  iclk        in   1           clock, all logic rising-edge
//  ireset      in   1           synchronous, active-high reset
//  i_req       in   NREQ        level request per requester; held until o_done/o_err bit
//  i_opa       in   NREQ*9*W    operand A per requester, row-major elem00..22, req0 in LSBs
//  i_opb       in   NREQ*9*W    operand B, same packing
//  o_grant     out  NREQ        one-hot, 1 cycle: operands of this requester captured
//  o_done      out  NREQ        one-hot, 1 cycle: o_res valid for this requester
//  o_err       out  NREQ        one-hot, 1 cycle: job aborted by watchdog, o_res = 0
//  o_res       out  9*W         result matrix, row-major, held until next o_done/o_err
//  o_busy      out  1           high from capture to done/err inclusive
//  o_mm_en     out  1           enable to shared Mat_Mul
//  o_mm_a      out  9*W         registered operand A to Mat_Mul
//  o_mm_b      out  9*W         registered operand B to Mat_Mul
//  i_mm_res    in   9*W         Mat_Mul result
//  i_mm_dval   in   1           Mat_Mul data valid
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = 0, watchdog = 0; in-flight job dropped,
//   no done/err issued for it; o_mm_en low on the cycle after reset asserts.
//  FSM: IDLE -> CAPT -> RUN -> RESP -> IDLE.
//   IDLE: if any i_req, pick first set bit at or after pointer (wrapping NREQ-1 -> 0); go CAPT.
//   CAPT: register winner's i_opa/i_opb into o_mm_a/o_mm_b, pulse o_grant, clear watchdog.
//   RUN : o_mm_en=1; watchdog++ each cycle. i_mm_dval=1 -> latch i_mm_res into o_res, go RESP.
//         watchdog reaches TIMEOUT-1 without dval -> o_res=0, flag err, go RESP.
//         dval and timeout on the same cycle: dval wins (result delivered, no err).
//   RESP: o_mm_en=0; pulse o_done (or o_err) for winner; pointer = winner+1 mod NREQ; IDLE.
//  Latency: request seen in IDLE -> o_grant 1 cycle later; i_mm_dval -> o_done 1 cycle later.
//   Minimum request-to-done = 3 + multiplier latency; back-to-back jobs gap = 1 IDLE cycle.
//  i_req sampled only in IDLE; requests rising during CAPT/RUN/RESP wait. Operands sampled only in
//   CAPT; requester may change them after o_grant.
//  Requester dropping i_req after grant: job completes, done still pulsed (no cancel).
//  i_mm_dval outside RUN ignored. o_mm_a/o_mm_b hold until next CAPT.
//  Arithmetic: no arithmetic on data; results passed bit-exact; watchdog $clog2(TIMEOUT)+1 bits,
//   saturates, never wraps.
//  Fairness: with all requests held high, grants rotate 0,1,..,NREQ-1,0.
// STRUCTURE
//  Shared package mat_pkg: W, FRAC_BITS=6, ONE_Q=64, MAT_ELEMS=9, sched state enum
//   {IDLE,CAPT,RUN,RESP}, packed 9*W matrix typedef + element index helper.
//  One sub-module: rr_arbiter (NREQ req, pointer in -> one-hot winner + index out, combinational).
//  Operand mux, FSM, watchdog, result register in this module.
// TESTING
//  1 Single req0, A=I*64, B=[[64,128,0],[0,64,0],[0,0,64]], mm model lat 4 -> grant cyc+1,
//    o_mm_en 4 cycles, o_done[0] with o_res=B, o_busy spans grant..done.
//  2 req0,req1,req2 held high from reset release -> grants 0,1,2,0,1,2, each with own operands.
//  3 req1 only while pointer=2 -> wrap: grant 1 immediately, next pointer 2.
//  4 mm model never asserts dval, TIMEOUT=64 -> o_err[winner] at RUN cycle 64, o_res=0, no o_done.
//  5 ireset for 1 cycle during RUN -> all outputs 0 next cycle, no done/err; fresh req served normally.
//  6 dval on last watchdog cycle -> o_done, o_err stays 0; stray dval in IDLE -> no output change.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared definitions for the matrix-sqrt datapath: Q.6 element format, 3x3 matrix packing
// and the shared-multiplier scheduler state encoding.
package mat_pkg;

    localparam int W         = 33;
    localparam int FRAC_BITS = 6;
    localparam int ONE_Q     = 64;
    localparam int MAT_ELEMS = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } sched_state_t;

    typedef logic [MAT_ELEMS*W-1:0] mat_t;

    // Bit offset of element (row, col) inside a row-major packed matrix of w-bit elements.
    function automatic int elem_lsb(input int row, input int col, input int w);
        return (row * 3 + col) * w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping to 0.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int            cand;
    logic [IW-1:0] cand_idx;

    // Scan from the farthest candidate to the nearest so the nearest one overwrites the rest.
    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IW'(cand);
            if (req[cand_idx]) begin
                grant           = '0;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
                any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/matmul_share_sched.sv
// Shares one 3x3 Q.6 matrix multiplier among NREQ requesters: round-robin grant, operand
// capture, watchdog-guarded wait for the multiplier, and a one-cycle done/err response.
module matmul_share_sched
    import mat_pkg::*;
#(
    parameter int W       = mat_pkg::W,
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                        iclk,
    input  logic                        ireset,
    input  logic [NREQ-1:0]             i_req,
    input  logic [NREQ*MAT_ELEMS*W-1:0] i_opa,
    input  logic [NREQ*MAT_ELEMS*W-1:0] i_opb,
    output logic [NREQ-1:0]             o_grant,
    output logic [NREQ-1:0]             o_done,
    output logic [NREQ-1:0]             o_err,
    output logic [MAT_ELEMS*W-1:0]      o_res,
    output logic                        o_busy,
    output logic                        o_mm_en,
    output logic [MAT_ELEMS*W-1:0]      o_mm_a,
    output logic [MAT_ELEMS*W-1:0]      o_mm_b,
    input  logic [MAT_ELEMS*W-1:0]      i_mm_res,
    input  logic                        i_mm_dval
);

    localparam int MW  = MAT_ELEMS * W;
    localparam int IW  = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT) + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    sched_state_t    state_reg, state_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [IW-1:0]   win_idx_reg;
    logic [NREQ-1:0] win_oh_reg;
    logic [WDW-1:0]  wd_reg;
    logic            err_reg;
    logic [MW-1:0]   mm_a_reg, mm_b_reg, res_reg;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    logic [MW-1:0]   opa_arr [NREQ];
    logic [MW-1:0]   opb_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_op_split
            assign opa_arr[gi] = i_opa[gi*MW +: MW];
            assign opb_arr[gi] = i_opb[gi*MW +: MW];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req   (i_req),
        .ptr   (ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign ptr_next = (win_idx_reg == IW'(NREQ - 1)) ? '0 : win_idx_reg + IW'(1);

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        o_grant    = '0;
        o_done     = '0;
        o_err      = '0;
        o_mm_en    = 1'b0;
        o_busy     = 1'b1;
        case (state_reg)
            IDLE: begin
                o_busy = 1'b0;
                if (arb_any) begin
                    state_next = CAPT;
                end
            end
            CAPT: begin
                o_grant    = win_oh_reg;
                state_next = RUN;
            end
            RUN: begin
                o_mm_en = 1'b1;
                if (i_mm_dval || (wd_reg == WD_LAST)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (err_reg) begin
                    o_err = win_oh_reg;
                end else begin
                    o_done = win_oh_reg;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            ptr_reg     <= '0;
            win_idx_reg <= '0;
            win_oh_reg  <= '0;
            wd_reg      <= '0;
            err_reg     <= 1'b0;
            mm_a_reg    <= '0;
            mm_b_reg    <= '0;
            res_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arb_any) begin
                        win_idx_reg <= arb_idx;
                        win_oh_reg  <= arb_grant;
                    end
                end
                CAPT: begin
                    mm_a_reg <= opa_arr[win_idx_reg];
                    mm_b_reg <= opb_arr[win_idx_reg];
                    wd_reg   <= '0;
                end
                RUN: begin
                    if (wd_reg != WD_LAST) begin
                        wd_reg <= wd_reg + WDW'(1);
                    end
                    // A result arriving on the final watchdog cycle still counts as delivered.
                    if (i_mm_dval) begin
                        res_reg <= i_mm_res;
                        err_reg <= 1'b0;
                    end else if (wd_reg == WD_LAST) begin
                        res_reg <= '0;
                        err_reg <= 1'b1;
                    end
                end
                RESP: begin
                    ptr_reg <= ptr_next;
                end
                default: ;
            endcase
        end
    end

    assign o_res  = res_reg;
    assign o_mm_a = mm_a_reg;
    assign o_mm_b = mm_b_reg;

endmodule

// File: tb/tb_matmul_share_sched.sv
// Randomized scoreboard bench for matmul_share_sched with a behavioural Q.6 multiplier model.
module tb_matmul_share_sched;
    import mat_pkg::*;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 64;
    localparam int MW      = MAT_ELEMS * W;
    localparam int MAXJ    = 8;

    typedef struct {
        int            r;
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [MW-1:0] res;
        bit            err;
        int            lat;
        bit            b2b;
    } job_t;

    logic                clk = 1'b0;
    logic                ireset;
    logic [NREQ-1:0]     i_req;
    logic [NREQ*MW-1:0]  i_opa, i_opb;
    logic [NREQ-1:0]     o_grant, o_done, o_err;
    logic [MW-1:0]       o_res, o_mm_a, o_mm_b, i_mm_res;
    logic                o_busy, o_mm_en, i_mm_dval;

    always #5 clk = ~clk;

    matmul_share_sched #(.W(W), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .iclk(clk), .ireset(ireset), .i_req(i_req), .i_opa(i_opa), .i_opb(i_opb),
        .o_grant(o_grant), .o_done(o_done), .o_err(o_err), .o_res(o_res), .o_busy(o_busy),
        .o_mm_en(o_mm_en), .o_mm_a(o_mm_a), .o_mm_b(o_mm_b),
        .i_mm_res(i_mm_res), .i_mm_dval(i_mm_dval)
    );

    int            total, bad, cyc, grant_cyc, last_done_cyc, mm_lat, en_cnt, mdl_ptr;
    int            cnt [NREQ];
    int            jobidx [NREQ];
    bit            garble [NREQ];
    bit            gpend [NREQ];
    bit            stray, mon_en, inflight, first_en, fixed_mode;
    logic [MW-1:0] ops_a [NREQ][MAXJ];
    logic [MW-1:0] ops_b [NREQ][MAXJ];
    logic [MW-1:0] last_res, fix_a, fix_b;
    job_t          exp_q[$];
    job_t          cur;

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic longint elem(input logic [MW-1:0] m, input int e);
        logic signed [W-1:0] v;
        v = m[e*W +: W];
        return longint'(v);
    endfunction

    // Reference 3x3 product in Q.6: sum of products, arithmetic shift by the fraction bits.
    function automatic logic [MW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] r;
        longint        s;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++) s += elem(a, i*3 + k) * elem(b, k*3 + j);
                s = s >>> FRAC_BITS;
                r[(i*3 + j)*W +: W] = s[W-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] r;
        int            v;
        r = '0;
        for (int e = 0; e < MAT_ELEMS; e++) begin
            v = int'($urandom_range(0, 65535)) - 32768;
            r[e*W +: W] = W'(v);
        end
        return r;
    endfunction

    task automatic apply();
        for (int r = 0; r < NREQ; r++) begin
            i_req[r] = (jobidx[r] < cnt[r]);
            if (!garble[r] && jobidx[r] < cnt[r] && jobidx[r] < MAXJ) begin
                i_opa[r*MW +: MW] = ops_a[r][jobidx[r]];
                i_opb[r*MW +: MW] = ops_b[r][jobidx[r]];
            end else begin
                i_opa[r*MW +: MW] = rand_mat();
                i_opb[r*MW +: MW] = rand_mat();
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: hold request while jobs remain; scramble operands once the grant cycle has passed.
    always @(negedge clk) begin
        for (int r = 0; r < NREQ; r++) begin
            if (o_done[r] || o_err[r]) begin
                jobidx[r]++;
                garble[r] = 1'b0;
                gpend[r]  = 1'b0;
            end else if (gpend[r]) begin
                garble[r] = 1'b1;
                gpend[r]  = 1'b0;
            end
            if (o_grant[r]) gpend[r] = 1'b1;
        end
        apply();
    end

    // Multiplier model: answers after mm_lat enabled cycles; mm_lat = 0 means it never answers.
    always @(negedge clk) begin
        if (o_mm_en) begin
            en_cnt++;
            if (mm_lat != 0 && en_cnt == mm_lat) begin
                i_mm_dval = 1'b1;
                i_mm_res  = matmul(o_mm_a, o_mm_b);
            end else begin
                i_mm_dval = 1'b0;
            end
        end else begin
            en_cnt    = 0;
            i_mm_dval = stray;
            if (stray) i_mm_res = rand_mat();
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_grant != '0) begin
                if (inflight || exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_grant actual=%b required=none", o_grant);
                end else begin
                    cur = exp_q[0];
                    chk("grant_onehot", MW'(o_grant), MW'(1 << cur.r));
                    if (cur.b2b) chk("b2b_gap", MW'(cyc - last_done_cyc), MW'(2));
                    grant_cyc = cyc;
                    inflight  = 1'b1;
                    first_en  = 1'b1;
                end
            end
            if (inflight && o_mm_en && first_en) begin
                chk("mm_a", o_mm_a, cur.a);
                chk("mm_b", o_mm_b, cur.b);
                first_en = 1'b0;
            end
            chk("busy", MW'(o_busy), MW'(inflight));
            if (o_done != '0 || o_err != '0) begin
                if (!inflight) begin
                    total++; bad++;
                    $display("FAIL unexpected_resp actual=done:%b err:%b required=none", o_done, o_err);
                end else begin
                    chk("done", MW'(o_done), cur.err ? '0 : MW'(1 << cur.r));
                    chk("err", MW'(o_err), cur.err ? MW'(1 << cur.r) : '0);
                    chk("res", o_res, cur.res);
                    chk("resp_latency", MW'(cyc - grant_cyc), MW'(cur.lat));
                    void'(exp_q.pop_front());
                    inflight      = 1'b0;
                    last_done_cyc = cyc;
                    last_res      = cur.res;
                end
            end
        end
    end

    // Builds operands, predicts the full service order from the round-robin rule, then starts.
    task automatic start_scenario(input int c0, input int c1, input int c2, input int lat);
        int   c [NREQ];
        int   rem [NREQ];
        int   jn [NREQ];
        int   p, pick;
        bit   first;
        job_t j;
        c[0] = c0; c[1] = c1; c[2] = c2;
        for (int r = 0; r < NREQ; r++) begin
            for (int k = 0; k < c[r]; k++) begin
                ops_a[r][k] = rand_mat();
                ops_b[r][k] = rand_mat();
            end
            rem[r] = c[r];
            jn[r]  = 0;
        end
        if (fixed_mode) begin
            ops_a[0][0] = fix_a;
            ops_b[0][0] = fix_b;
        end
        p = mdl_ptr;
        first = 1'b1;
        while (rem[0] + rem[1] + rem[2] > 0) begin
            pick = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (pick < 0 && rem[(p + k) % NREQ] > 0) pick = (p + k) % NREQ;
            end
            j.r   = pick;
            j.a   = ops_a[pick][jn[pick]];
            j.b   = ops_b[pick][jn[pick]];
            j.err = (lat == 0 || lat > TIMEOUT);
            j.res = j.err ? '0 : matmul(j.a, j.b);
            j.lat = (j.err ? TIMEOUT : lat) + 1;
            j.b2b = !first;
            first = 1'b0;
            exp_q.push_back(j);
            jn[pick]++;
            rem[pick]--;
            p = (pick + 1) % NREQ;
        end
        mdl_ptr = p;
        mm_lat  = lat;
        @(negedge clk);
        for (int r = 0; r < NREQ; r++) begin
            jobidx[r] = 0;
            garble[r] = 1'b0;
            gpend[r]  = 1'b0;
            cnt[r]    = c[r];
        end
        apply();
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || inflight) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || inflight) begin
            total++; bad++;
            $display("FAIL drain_timeout actual=%0d_pending required=0_pending", exp_q.size());
            exp_q.delete();
            inflight = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, MW'(o_grant), '0);
        chk({tag, "_done"},  MW'(o_done),  '0);
        chk({tag, "_err"},   MW'(o_err),   '0);
        chk({tag, "_busy"},  MW'(o_busy),  '0);
        chk({tag, "_mm_en"}, MW'(o_mm_en), '0);
        chk({tag, "_res"},   o_res,        '0);
        chk({tag, "_mm_a"},  o_mm_a,       '0);
        chk({tag, "_mm_b"},  o_mm_b,       '0);
    endtask

    initial begin
        int n;
        total = 0; bad = 0; cyc = 0; grant_cyc = 0; last_done_cyc = 0; en_cnt = 0;
        mm_lat = 1; mdl_ptr = 0; stray = 0; mon_en = 0; inflight = 0; first_en = 0;
        fixed_mode = 0; last_res = '0;
        for (int r = 0; r < NREQ; r++) begin
            cnt[r] = 0; jobidx[r] = 0; garble[r] = 0; gpend[r] = 0;
        end
        fix_a = '0;
        fix_b = '0;
        for (int d = 0; d < 3; d++) begin
            fix_a[elem_lsb(d, d, W) +: W] = W'(ONE_Q);
            fix_b[elem_lsb(d, d, W) +: W] = W'(ONE_Q);
        end
        fix_b[elem_lsb(0, 1, W) +: W] = W'(2 * ONE_Q);
        ireset = 1'b1; i_req = '0; i_opa = '0; i_opb = '0; i_mm_dval = 1'b0; i_mm_res = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        ireset = 1'b0;
        mon_en = 1'b1;

        // All three requesters held from reset release: grants 0,1,2,0,1,2.
        start_scenario(2, 2, 2, int'($urandom_range(1, 6)));
        wait_drain(3000);

        // Identity times B returns B; grant appears one cycle after the request.
        fixed_mode = 1'b1;
        start_scenario(1, 0, 0, 4);
        fixed_mode = 1'b0;
        @(negedge clk);
        chk("grant_after_1cyc", MW'(o_grant), MW'(1));
        wait_drain(500);
        chk("identity_product", o_res, fix_b);

        // Pointer wrap: req1 alone twice, then req0+req2 served 2 then 0.
        start_scenario(0, 1, 0, 3);
        wait_drain(500);
        start_scenario(0, 1, 0, 2);
        wait_drain(500);
        start_scenario(1, 0, 1, 5);
        wait_drain(500);

        // Watchdog abort, answer on the last allowed cycle, and answer one cycle too late.
        start_scenario(0, 0, 1, 0);
        wait_drain(500);
        chk("timeout_res_zero", o_res, '0);
        start_scenario(1, 0, 0, TIMEOUT);
        wait_drain(500);
        start_scenario(0, 1, 0, TIMEOUT + 1);
        wait_drain(500);

        // Stray data-valid while idle must not disturb anything.
        stray = 1'b1;
        repeat (4) @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_res_held", o_res, last_res);
        chk("stray_busy", MW'(o_busy), '0);

        // Reset in the middle of a job drops it silently.
        start_scenario(0, 0, 1, 0);
        n = 0;
        while (!o_mm_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_run", MW'(o_mm_en), MW'(1));
        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        for (int r = 0; r < NREQ; r++) cnt[r] = 0;
        ireset = 1'b1;
        @(negedge clk);
        ireset = 1'b0;
        chk_all_zero("midrun_reset");
        exp_q.delete();
        inflight = 1'b0;
        mdl_ptr  = 0;
        for (int r = 0; r < NREQ; r++) begin
            jobidx[r] = 0; garble[r] = 0; gpend[r] = 0;
        end
        @(negedge clk);
        chk("post_reset_done", MW'(o_done | o_err), '0);
        mon_en = 1'b1;
        start_scenario(0, 1, 0, 3);
        wait_drain(500);

        for (int it = 0; it < 12; it++) begin
            int c0, c1, c2;
            c0 = int'($urandom_range(0, 2));
            c1 = int'($urandom_range(0, 2));
            c2 = int'($urandom_range(0, 2));
            if (c0 + c1 + c2 == 0) c1 = 1;
            start_scenario(c0, c1, c2, int'($urandom_range(1, 10)));
            wait_drain(3000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
